mem_arbiter: RTL and testbench

- Single owner of the MemoryUnit request port; three requesters: instruction-line refill (I), LSB load (L), committed LSB store (S).
- Grants one transaction at a time, holds it stable until MemoryUnit signals completion, then routes the result back to the winner.
- Enforces clear (flush) semantics and UART back-pressure, plus a starvation guard for I.

---
 rtl/mem_arbiter_pkg.sv | 45 ++++
 rtl/mem_arb_pick.sv | 42 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory-port arbiter.
// Pure definitions: no latency, no flow control.
// Backpressure: not applicable.
package mem_arbiter_pkg;

  localparam int LSB_CAP_BIT = 3;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // addr[17:16] selects the memory-mapped IO window
  localparam logic [1:0] IO_REGION = 2'b11;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_I = 0;
  localparam int GNT_L = 1;
  localparam int GNT_S = 2;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_I    = 2'd1,
    REQ_L    = 2'd2,
    REQ_S    = 2'd3
  } req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic        typ;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic logic is_io(input logic [1:0] region);
    return region == IO_REGION;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Priority picker: S > L > I, starvation override for I, IO ordering rules.
// Latency: combinational, one-hot grant valid in the same cycle.
// Backpressure: a blocked requester simply loses; the next eligible one wins.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       l_req,
  input  logic       s_req,
  input  logic       clear,
  input  logic       io_buffer_full,
  input  logic       starve,
  input  logic [1:0] l_region,
  input  logic [1:0] s_region,
  output logic [2:0] grant
);

  logic io_store_pending;
  logic s_ok;
  logic l_ok;
  logic i_ok;

  // An IO load must not overtake a pending IO store, even a blocked one
  assign io_store_pending = s_req && is_io(s_region);
  assign s_ok = s_req && !(is_io(s_region) && io_buffer_full);
  assign l_ok = l_req && !clear && !(is_io(l_region) && io_store_pending);
  assign i_ok = i_req && !clear;

  always_comb begin
    grant = '0;
    if (starve && i_ok) begin
      grant[GNT_I] = 1'b1;
    end else if (s_ok) begin
      grant[GNT_S] = 1'b1;
    end else if (l_ok) begin
      grant[GNT_L] = 1'b1;
    end else if (i_ok) begin
      grant[GNT_I] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single owner of the MemoryUnit port; grants one of I/L/S and routes the result.
// Latency: m_req one cycle after the winning request; done pulse one cycle after m_done.
// Backpressure: rdy_in low freezes everything; io_buffer_full blocks IO stores.
module mem_arbiter #(
  parameter int LSB_CAP_BIT  = mem_arbiter_pkg::LSB_CAP_BIT,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   io_buffer_full,
  input  logic                   i_req,
  input  logic [31:0]            i_addr,
  output logic                   i_done,
  input  logic                   l_req,
  input  logic [31:0]            l_addr,
  input  logic [1:0]             l_size,
  input  logic [LSB_CAP_BIT-1:0] l_pos,
  output logic                   l_done,
  output logic [31:0]            l_data,
  output logic [LSB_CAP_BIT-1:0] l_pos_out,
  input  logic                   s_req,
  input  logic [31:0]            s_addr,
  input  logic [1:0]             s_size,
  input  logic [31:0]            s_data,
  output logic                   s_done,
  output logic                   m_req,
  output logic                   m_we,
  output logic                   m_type,
  output logic [31:0]            m_addr,
  output logic [1:0]             m_size,
  output logic [31:0]            m_wdata,
  output logic                   m_abort,
  input  logic                   m_done,
  input  logic [31:0]            m_rdata
);
  import mem_arbiter_pkg::*;

  arb_state_t             state;
  req_id_t                owner;
  mem_cmd_t               cmd;
  logic [LSB_CAP_BIT-1:0] tag_q;
  logic [CNT_W-1:0]       starve_cnt;
  logic [2:0]             grant;
  logic                   starve;

  assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT));

  mem_arb_pick u_pick (
    .i_req          (i_req),
    .l_req          (l_req),
    .s_req          (s_req),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .starve         (starve),
    .l_region       (l_addr[17:16]),
    .s_region       (s_addr[17:16]),
    .grant          (grant)
  );

  // The MemoryUnit only ever sees the latched command
  assign m_we    = cmd.we;
  assign m_type  = cmd.typ;
  assign m_addr  = cmd.addr;
  assign m_size  = cmd.size;
  assign m_wdata = cmd.wdata;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state      <= ST_IDLE;
      owner      <= REQ_NONE;
      cmd        <= '0;
      tag_q      <= '0;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_abort    <= 1'b0;
      i_done     <= 1'b0;
      l_done     <= 1'b0;
      s_done     <= 1'b0;
      l_data     <= '0;
      l_pos_out  <= '0;
    end else if (rdy_in) begin
      i_done  <= 1'b0;
      l_done  <= 1'b0;
      s_done  <= 1'b0;
      m_abort <= 1'b0;

      if (!i_req || (state == ST_IDLE && grant[GNT_I])) begin
        starve_cnt <= '0;
      end else if ((state == ST_IDLE || state == ST_BUSY) && owner != REQ_I &&
                   !starve) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (grant[GNT_S]) begin
            owner <= REQ_S;
            cmd   <= '{we: 1'b1, typ: 1'b1, addr: s_addr, size: s_size, wdata: s_data};
            m_req <= 1'b1;
            state <= ST_BUSY;
          end else if (grant[GNT_L]) begin
            owner <= REQ_L;
            cmd   <= '{we: 1'b0, typ: 1'b1, addr: l_addr, size: l_size, wdata: 32'h0};
            tag_q <= l_pos;
            m_req <= 1'b1;
            state <= ST_BUSY;
          end else if (grant[GNT_I]) begin
            owner <= REQ_I;
            cmd   <= '{we: 1'b0, typ: 1'b0, addr: i_addr, size: SIZE_WORD, wdata: 32'h0};
            m_req <= 1'b1;
            state <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (clear && owner != REQ_S) begin
            // Flushed read: nothing to abort if it completed this very cycle
            m_abort <= !m_done;
            m_req   <= 1'b0;
            owner   <= REQ_NONE;
            state   <= ST_IDLE;
          end else if (m_done) begin
            m_req <= 1'b0;
            owner <= REQ_NONE;
            state <= ST_IDLE;
            case (owner)
              REQ_I: i_done <= 1'b1;
              REQ_L: begin
                l_done    <= 1'b1;
                l_data    <= m_rdata;
                l_pos_out <= tag_q;
              end
              REQ_S: s_done <= 1'b1;
              default: ;
            endcase
          end
        end

        ST_DROP: begin
          if (m_done) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, priority, starvation, IO ordering, flush, stall.
module tb_mem_arbiter;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear;
  logic        io_buffer_full;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic        l_req;
  logic [31:0] l_addr;
  logic [1:0]  l_size;
  logic [2:0]  l_pos;
  logic        l_done;
  logic [31:0] l_data;
  logic [2:0]  l_pos_out;
  logic        s_req;
  logic [31:0] s_addr;
  logic [1:0]  s_size;
  logic [31:0] s_data;
  logic        s_done;
  logic        m_req;
  logic        m_we;
  logic        m_type;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  logic [31:0] m_wdata;
  logic        m_abort;
  logic        m_done;
  logic [31:0] m_rdata;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.LSB_CAP_BIT(3), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
    .io_buffer_full(io_buffer_full),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .l_req(l_req), .l_addr(l_addr), .l_size(l_size), .l_pos(l_pos),
    .l_done(l_done), .l_data(l_data), .l_pos_out(l_pos_out),
    .s_req(s_req), .s_addr(s_addr), .s_size(s_size), .s_data(s_data), .s_done(s_done),
    .m_req(m_req), .m_we(m_we), .m_type(m_type), .m_addr(m_addr), .m_size(m_size),
    .m_wdata(m_wdata), .m_abort(m_abort), .m_done(m_done), .m_rdata(m_rdata)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs;
    rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    i_req = 1'b0; i_addr = '0;
    l_req = 1'b0; l_addr = '0; l_size = 2'd2; l_pos = '0;
    s_req = 1'b0; s_addr = '0; s_size = 2'd2; s_data = '0;
    m_done = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n_in = 1'b0;
    tick(); tick();
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    i_req = 1'b1; i_addr = 32'h0000_3000;
    l_req = 1'b1; l_addr = 32'h0000_2000; l_pos = 3'd1;
    s_req = 1'b1; s_addr = 32'h0000_1000; s_data = 32'h1111_2222;
    rst_n_in = 1'b0;
    tick(); tick();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_m_req got=%0h want=0", m_req); end
    checks++; if ({i_done, l_done, s_done, m_abort} !== 4'b0) begin errors++;
      $display("FAIL rst_dones got=%b want=0000", {i_done, l_done, s_done, m_abort}); end
    checks++; if ({m_we, m_type, m_addr, m_size, m_wdata} !== 68'h0) begin errors++;
      $display("FAIL rst_m_cmd got addr=%h we=%b want all zero", m_addr, m_we); end
    checks++; if ({l_data, l_pos_out} !== 35'h0) begin errors++;
      $display("FAIL rst_l_out got=%h/%h want=0/0", l_data, l_pos_out); end
    rst_n_in = 1'b1;
    tick();
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h0000_1000 || m_we !== 1'b1) begin errors++;
      $display("FAIL rst_first_grant got req=%b addr=%h we=%b want 1/00001000/1", m_req, m_addr, m_we); end
    m_done = 1'b1;
    tick();
    checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL rst_s_done got=%b want=1", s_done); end
    idle_inputs();
    tick();
  endtask

  task automatic test_priority;
    do_reset();
    s_req = 1'b1; s_addr = 32'h0000_0100; s_data = 32'hA5A5_A5A5;
    l_req = 1'b1; l_addr = 32'h0000_0200; l_pos = 3'd5;
    i_req = 1'b1; i_addr = 32'h0000_0300;
    tick();
    checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h0000_0100 || m_wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL prio_first_s got req=%b we=%b addr=%h want 1/1/00000100", m_req, m_we, m_addr); end
    repeat (3) tick();
    m_done = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    m_done = 1'b0;
    checks++; if (s_done !== 1'b1 || m_req !== 1'b0 || l_done !== 1'b0) begin errors++;
      $display("FAIL prio_s_done got s=%b l=%b req=%b want 1/0/0", s_done, l_done, m_req); end
    s_req = 1'b0;
    tick();
    checks++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_type !== 1'b1 || m_addr !== 32'h0000_0200) begin
      errors++; $display("FAIL prio_second_l got we=%b type=%b addr=%h want 0/1/00000200", m_we, m_type, m_addr); end
    l_addr = 32'h0000_DEAD; l_pos = 3'd0;
    tick();
    checks++; if (m_addr !== 32'h0000_0200) begin errors++;
      $display("FAIL prio_latched_addr got=%h want=00000200", m_addr); end
    tick(); tick();
    m_done = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    m_done = 1'b0;
    checks++; if (l_done !== 1'b1 || l_data !== 32'h1234_5678 || l_pos_out !== 3'd5) begin errors++;
      $display("FAIL prio_l_done got done=%b data=%h pos=%0d want 1/12345678/5", l_done, l_data, l_pos_out); end
    l_req = 1'b0;
    tick();
    checks++; if (m_req !== 1'b1 || m_type !== 1'b0 || m_addr !== 32'h0000_0300) begin errors++;
      $display("FAIL prio_third_i got type=%b addr=%h want 0/00000300", m_type, m_addr); end
    repeat (3) tick();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++; if (i_done !== 1'b1 || l_done !== 1'b0 || s_done !== 1'b0) begin errors++;
      $display("FAIL prio_i_done got i=%b l=%b s=%b want 1/0/0", i_done, l_done, s_done); end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation;
    logic exp_type;
    do_reset();
    l_req = 1'b1; l_addr = 32'h0000_0700;
    i_req = 1'b1; i_addr = 32'h0000_0800;
    m_done = 1'b1;
    // L grants on edges 1,3,5,7 push the counter to 8; edge 9 must go to I
    for (int g = 0; g < 5; g++) begin
      exp_type = (g < 4);
      tick();
      checks++; if (m_req !== 1'b1 || m_type !== exp_type) begin errors++;
        $display("FAIL starve_grant%0d got req=%b type=%b want 1/%b", g, m_req, m_type, exp_type); end
      tick();
      checks++; if (i_done !== !exp_type || l_done !== exp_type) begin errors++;
        $display("FAIL starve_done%0d got i=%b l=%b want %b/%b", g, i_done, l_done, !exp_type, exp_type); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_io;
    do_reset();
    s_req = 1'b1; s_addr = 32'h0003_0000; s_data = 32'h0000_0041;
    io_buffer_full = 1'b1;
    l_req = 1'b1; l_addr = 32'h0000_0100; l_pos = 3'd2;
    tick();
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h0000_0100 || m_we !== 1'b0) begin errors++;
      $display("FAIL io_nonio_load got addr=%h we=%b want 00000100/0", m_addr, m_we); end
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++; if (l_done !== 1'b1 || l_pos_out !== 3'd2) begin errors++;
      $display("FAIL io_nonio_done got done=%b pos=%0d want 1/2", l_done, l_pos_out); end
    l_addr = 32'h0003_0004; l_pos = 3'd4;
    repeat (3) tick();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL io_blocked got req=%b want=0", m_req); end
    io_buffer_full = 1'b0;
    tick();
    checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h0003_0000) begin errors++;
      $display("FAIL io_store_first got we=%b addr=%h want 1/00030000", m_we, m_addr); end
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL io_store_done got=%b want=1", s_done); end
    s_req = 1'b0;
    tick();
    checks++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h0003_0004) begin errors++;
      $display("FAIL io_load_after got we=%b addr=%h want 0/00030004", m_we, m_addr); end
    m_done = 1'b1;
    tick();
    checks++; if (l_done !== 1'b1 || l_pos_out !== 3'd4) begin errors++;
      $display("FAIL io_load_done got done=%b pos=%0d want 1/4", l_done, l_pos_out); end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush;
    do_reset();
    l_req = 1'b1; l_addr = 32'h0000_0400;
    tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL flush_l_grant got=%b want=1", m_req); end
    l_req = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (m_abort !== 1'b1 || m_req !== 1'b0 || l_done !== 1'b0) begin errors++;
      $display("FAIL flush_abort got abort=%b req=%b ldone=%b want 1/0/0", m_abort, m_req, l_done); end
    tick();
    checks++; if (m_abort !== 1'b0 || l_done !== 1'b0 || m_req !== 1'b0) begin errors++;
      $display("FAIL flush_abort_len got abort=%b ldone=%b req=%b want 0/0/0", m_abort, l_done, m_req); end
    s_req = 1'b1; s_addr = 32'h0000_0500; s_data = 32'h0000_00A5;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_abort !== 1'b0) begin errors++;
      $display("FAIL flush_store_kept got req=%b we=%b abort=%b want 1/1/0", m_req, m_we, m_abort); end
    m_done = 1'b1;
    tick();
    m_done = 1'b0; s_req = 1'b0;
    checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL flush_store_done got=%b want=1", s_done); end
    tick();
    l_req = 1'b1; l_addr = 32'h0000_0600; clear = 1'b1;
    tick();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL flush_idle_block got=%b want=0", m_req); end
    clear = 1'b0;
    tick();
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h0000_0600) begin errors++;
      $display("FAIL flush_idle_release got req=%b addr=%h want 1/00000600", m_req, m_addr); end
    l_req = 1'b0; m_done = 1'b1; clear = 1'b1;
    tick();
    checks++; if (l_done !== 1'b0 || m_req !== 1'b0) begin errors++;
      $display("FAIL flush_done_race got ldone=%b req=%b want 0/0", l_done, m_req); end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall;
    int pulses;
    do_reset();
    l_req = 1'b1; l_addr = 32'h0000_0900; l_pos = 3'd3;
    tick();
    m_done = 1'b1; m_rdata = 32'hCAFE_F00D; rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (m_req !== 1'b1 || l_done !== 1'b0 || l_data !== 32'h0) begin errors++;
        $display("FAIL stall_hold%0d got req=%b ldone=%b data=%h want 1/0/0", c, m_req, l_done, l_data); end
    end
    rdy_in = 1'b1;
    pulses = 0;
    tick();
    checks++; if (l_done !== 1'b1 || l_data !== 32'hCAFE_F00D || m_req !== 1'b0) begin errors++;
      $display("FAIL stall_release got ldone=%b data=%h req=%b want 1/cafef00d/0", l_done, l_data, m_req); end
    if (l_done === 1'b1) pulses++;
    m_done = 1'b0; l_req = 1'b0;
    repeat (3) begin
      tick();
      if (l_done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL stall_pulses got=%0d want=1", pulses); end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_n_in = 1'b0;
    test_reset();
    test_priority();
    test_starvation();
    test_io();
    test_flush();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
